// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// Module   : display_scan
// Purpose  : Snapshots six BCD time digits (HH:MM:SS) once per frame. It then
//            time-multiplexes them onto a shared 7-segment bus with one-hot
//            digit enables. Each digit slot starts with a blanking gap to
//            suppress ghosting, and an optional dark leading hour-tens zero
//            is supported. All outputs are registered and can drive pins
//            directly.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan #(
  parameter int REFRESH_DIV  = 1000,  // clk cycles per digit slot (2..65535)
  parameter int BLANK_CYCLES = 16     // dark cycles at slot start (1..REFRESH_DIV-1)
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ena,
  input  logic [23:0] digits_in,
  input  logic [5:0]  dp_in,
  input  logic        lz_blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  dig_sel,
  output logic        frame_start
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [15:0] C_PCNT_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] C_BLANK     = 16'(BLANK_CYCLES);
  localparam logic [2:0]  C_SLOT_LAST = 3'd5;
  localparam logic [2:0]  C_SLOT_HRT  = 3'd5;   // hour-tens digit position
  localparam logic [6:0]  C_SEG_DASH  = 7'h40;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [15:0] pcnt;          // position inside the current digit slot
  logic [2:0]  slot;          // digit currently being scanned, 0..5
  logic [23:0] shadow_dig;    // frame-stable copy of digits_in
  logic [5:0]  shadow_dp;     // frame-stable copy of dp_in

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        pcnt_wrap;     // last cycle of a slot
  logic        snap;          // snapshot edge: start of frame while enabled
  logic        show;          // slot is past its blanking gap
  logic [3:0]  cur_nib;       // shadow nibble of the current slot
  logic        cur_dp;        // shadow decimal point of the current slot
  logic [6:0]  seg_dec;       // decoded segments of cur_nib
  logic        lz_kill;       // suppress a leading hour-tens zero
  logic [5:0]  sel_dec;       // one-hot enable for the current slot

  assign pcnt_wrap = (pcnt == C_PCNT_LAST);
  assign snap      = ena && (slot == 3'd0) && (pcnt == 16'd0);
  assign show      = ena && (pcnt >= C_BLANK);
  assign lz_kill   = lz_blank && (slot == C_SLOT_HRT) && (cur_nib == 4'd0);

  // Select the shadow nibble and decimal point that belong to the current slot.
  always_comb begin
    cur_nib = 4'd0;
    cur_dp  = 1'b0;
    sel_dec = 6'b000000;
    case (slot)
      3'd0: begin cur_nib = shadow_dig[3:0];   cur_dp = shadow_dp[0]; sel_dec = 6'b000001; end
      3'd1: begin cur_nib = shadow_dig[7:4];   cur_dp = shadow_dp[1]; sel_dec = 6'b000010; end
      3'd2: begin cur_nib = shadow_dig[11:8];  cur_dp = shadow_dp[2]; sel_dec = 6'b000100; end
      3'd3: begin cur_nib = shadow_dig[15:12]; cur_dp = shadow_dp[3]; sel_dec = 6'b001000; end
      3'd4: begin cur_nib = shadow_dig[19:16]; cur_dp = shadow_dp[4]; sel_dec = 6'b010000; end
      3'd5: begin cur_nib = shadow_dig[23:20]; cur_dp = shadow_dp[5]; sel_dec = 6'b100000; end
      default: begin
        cur_nib = 4'd0;
        cur_dp  = 1'b0;
        sel_dec = 6'b000000;
      end
    endcase
  end

  // BCD to 7-segment decode; non-BCD codes show a dash so bad data is visible.
  always_comb begin
    seg_dec = C_SEG_DASH;
    case (cur_nib)
      4'd0:    seg_dec = 7'h3F;
      4'd1:    seg_dec = 7'h06;
      4'd2:    seg_dec = 7'h5B;
      4'd3:    seg_dec = 7'h4F;
      4'd4:    seg_dec = 7'h66;
      4'd5:    seg_dec = 7'h6D;
      4'd6:    seg_dec = 7'h7D;
      4'd7:    seg_dec = 7'h07;
      4'd8:    seg_dec = 7'h7F;
      4'd9:    seg_dec = 7'h6F;
      default: seg_dec = C_SEG_DASH;
    endcase
  end

  // Prescaler and slot counter; both freeze while scanning is disabled.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pcnt <= 16'd0;
      slot <= 3'd0;
    end else if (ena) begin
      if (pcnt_wrap) begin
        pcnt <= 16'd0;
        slot <= (slot == C_SLOT_LAST) ? 3'd0 : slot + 3'd1;
      end else begin
        pcnt <= pcnt + 16'd1;
      end
    end
  end

  // Capture the digits at the frame start. This edge always lies inside a
  // blanking gap, so a visible frame never mixes old and new digits.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      shadow_dig <= 24'd0;
      shadow_dp  <= 6'd0;
    end else if (snap) begin
      shadow_dig <= digits_in;
      shadow_dp  <= dp_in;
    end
  end

  // Register all pin outputs from the present counter and shadow state.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      seg         <= 7'd0;
      dp          <= 1'b0;
      dig_sel     <= 6'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap;
      if (show) begin
        dig_sel <= sel_dec;
        seg     <= lz_kill ? 7'd0 : seg_dec;
        dp      <= cur_dp;
      end else begin
        dig_sel <= 6'd0;
        seg     <= 7'd0;
        dp      <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan
// Purpose  : Self-checking bench for display_scan. A frame-level model
//            derives the expected pin values from the enabled-cycle count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan;

  localparam int D = 8;   // REFRESH_DIV
  localparam int B = 2;   // BLANK_CYCLES

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        ena = 1'b0;
  logic [23:0] digits_in = 24'd0;
  logic [5:0]  dp_in = 6'd0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  dig_sel;
  logic        frame_start;

  int checks = 0;
  int failures = 0;

  display_scan #(.REFRESH_DIV(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .res(res), .ena(ena), .digits_in(digits_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg), .dp(dp), .dig_sel(dig_sel),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Model state: enabled edges since reset plus the captured frame data.
  int          n = 0;
  logic [23:0] m_dig = 24'd0;
  logic [5:0]  m_dp = 6'd0;
  logic [6:0]  dec_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge: predict the outputs, let the edge happen, then compare.
  task automatic cycle();
    logic [6:0] e_seg = 7'd0;
    logic       e_dp = 1'b0;
    logic [5:0] e_sel = 6'd0;
    logic       e_fs = 1'b0;
    int         p, s;
    logic [3:0] nib;
    if (res && ena) begin
      p = n % D;
      s = (n / D) % 6;
      e_fs = (n % (6 * D)) == 0;
      if (p >= B) begin
        nib   = m_dig[4*s +: 4];
        e_sel = 6'(1 << s);
        e_seg = (nib > 4'd9) ? 7'h40 : dec_tbl[nib];
        if (lz_blank && s == 5 && nib == 4'd0) e_seg = 7'd0;
        e_dp  = m_dp[s];
      end
      if (e_fs) begin
        m_dig = digits_in;
        m_dp  = dp_in;
      end
      n++;
    end
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("dig_sel", 32'(dig_sel), 32'(e_sel));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("onehot0", 32'($onehot0(dig_sel)), 32'd1);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must drop at once.
  task automatic async_reset();
    #2;
    res = 1'b0;
    #1;
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_sel", 32'(dig_sel), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    n = 0;
    m_dig = 24'd0;
    m_dp = 6'd0;
    #1;
    res = 1'b1;
  endtask

  task automatic run_to(input int pos);
    for (int k = 0; k < 6 * D && (n % (6 * D)) != pos; k++) cycle();
  endtask

  initial begin
    // Reset state.
    #1;
    check("reset_seg", 32'(seg), 32'd0);
    check("reset_sel", 32'(dig_sel), 32'd0);
    for (int i = 0; i < 3; i++) cycle();

    // First frame after reset, with digits changed during slot 2.
    ena = 1'b1;
    digits_in = 24'h123456;
    #3 res = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("first_digit_seg", 32'(seg), 32'h7D);
    check("first_digit_sel", 32'(dig_sel), 32'h01);
    run_to(2 * D + 3);
    digits_in = 24'h999999;
    for (int i = 0; i < 12 * D; i++) cycle();

    // Dash, leading-zero blanking on and off, and decimal points.
    digits_in = 24'h0A0000;
    dp_in = 6'b010100;
    lz_blank = 1'b1;
    for (int i = 0; i < 12 * D; i++) cycle();
    lz_blank = 1'b0;
    for (int i = 0; i < 6 * D; i++) cycle();

    // Freeze mid slot 3 for 20 cycles, then resume.
    digits_in = 24'h987654;
    run_to(3 * D + 4);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    ena = 1'b1;
    for (int i = 0; i < 6 * D; i++) cycle();

    // Asynchronous reset mid slot 4.
    run_to(4 * D + 4);
    async_reset();
    for (int i = 0; i < 7 * D; i++) cycle();

    // Randomized phase.
    for (int i = 0; i < 2500; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) digits_in = 24'($urandom);
      if ($urandom_range(0, 29) == 0) dp_in = 6'($urandom);
      if ($urandom_range(0, 49) == 0) lz_blank = 1'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
